clk_health_fsm: RTL and testbench
=================================

// Module: clk_health_fsm
// PURPOSE
//  Downstream consumer of one clock-monitor channel's rate/lock outputs.
//  - Qualifies each rate measurement against a programmable window.
//  - Debounces good/bad verdicts with consecutive-sample counters.
//  - Flags a stale (missing) measurement stream.
//  - Produces live and sticky alarms for the register map / interrupt logic.
//  - One instance per monitored clock, all in the clk_ref domain.
// PARAMETERS
//  RATE_W       24         width of rate and threshold inputs (matches monitor rate field)
//  CNT_W        4          width of n_bad/n_good debounce thresholds and internal counter
//  TIMEOUT_CYC  150000000  clk_ref cycles without rate_valid before stale (1.5 s at 100 MHz)
//  TO_W         28         width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk_ref       in   1       sole clock, 100 MHz reference domain
//  reset         in   1       asynchronous, active-high reset
//  rate          in   RATE_W  latest measured rate, valid when rate_valid=1
//  rate_valid    in   1       1-cycle strobe per new measurement
//  locked        in   1       PLL/MMCM lock of monitored clock (already synchronised)
//  rate_min      in   RATE_W  inclusive lower bound of good window
//  rate_max      in   RATE_W  inclusive upper bound of good window
//  n_bad         in   CNT_W   consecutive bad samples to enter FAIL (0 treated as 1)
//  n_good        in   CNT_W   consecutive good samples to leave FAIL (0 treated as 1)
//  alarm_clear   in   1       1-cycle pulse: clears alarm_sticky and bad_events
//  status        out  3       state: 0 INIT, 1 OK, 2 SUSPECT, 3 FAIL, 4 RECOVER
//  alarm         out  1       1 while status==FAIL
//  alarm_sticky  out  1       set on any entry to FAIL, held until alarm_clear
//  bad_events    out  16      count of bad samples, saturates at 16'hFFFF
//  stale         out  1       1 once TIMEOUT_CYC elapses with no rate_valid
// BEHAVIOUR
//  Reset: status=INIT; all outputs, debounce counter and timeout counter = 0.
//  Registered outputs; each responds on the clk_ref edge after the causing input.
//  Sample verdict, evaluated only when rate_valid=1, thresholds read live that cycle:
//  - good = locked && rate>=rate_min && rate<=rate_max
//  - bad otherwise; rate_min>rate_max makes every sample bad
//  Let nb = max(n_bad,1), ng = max(n_good,1), cnt = debounce counter.
//  INIT:    good -> OK. Bad -> cnt=1, then FAIL if nb==1, else SUSPECT.
//  OK:      bad -> cnt=1, then FAIL if nb==1, else SUSPECT. Good -> stay.
//  SUSPECT: good -> OK, cnt=0. Bad -> cnt++, and FAIL (cnt=0) when cnt+1==nb.
//  FAIL:    bad -> stay, cnt=0. Good -> OK if ng==1, else RECOVER with cnt=1.
//  RECOVER: bad -> FAIL, cnt=0. Good -> cnt++, and OK (cnt=0) when cnt+1==ng.
//  Lock loss: locked=0 in any cycle (with or without rate_valid) forces FAIL, cnt=0.
//  - Overrides the state-table transitions that cycle.
//  Timeout:
//  - Counter clears on rate_valid, else increments, saturating at TIMEOUT_CYC.
//  - Reaching TIMEOUT_CYC sets stale=1 and forces FAIL from any state, INIT included.
//  - Fires once per gap; the next rate_valid clears stale and is judged normally.
//  alarm_sticky: set-dominant. FAIL entry in the same cycle as alarm_clear leaves it 1.
//  bad_events: +1 per bad sample, saturating.
//  - alarm_clear with a simultaneous bad sample gives 1.
//  - alarm_clear with no bad sample gives 0.
//  alarm_clear does not change status or stale.
//  Changing n_bad/n_good mid-count: comparison uses the new value. Crossing already passed -> next sample decides.
// TESTING
//  1 min=99000,max=101000,nb=3,ng=2; strobe rate=100000 -> status 1, alarm 0, bad_events 0
//  2 From OK, 3 strobes rate=50000 -> status 2,2,3; alarm=alarm_sticky=1 after 3rd; bad_events=3
//  3 From FAIL, 2 strobes rate=100000 -> status 4 then 1; alarm 0, sticky 1.
//    Then alarm_clear -> sticky 0, bad_events 0
//  4 In OK, locked=0 for one cycle, no strobe -> status 3 next cycle, sticky 1, bad_events unchanged
//  5 TIMEOUT_CYC=1000, no strobe for 1000 cycles -> stale=1, status 3 at cycle 1000.
//    Then good strobe -> stale 0, status 4
//  6 Edges: rate=101000 counts good. alarm_clear on FAIL-entry cycle -> sticky 1.
//    alarm_clear with bad strobe -> bad_events=1. nb=0 behaves as nb=1.

Source files
------------

// File: rtl/clk_health_fsm_if.sv
// ---------------------------------------------------------------------------
// clk_health_fsm_if
// Bundles one clock-monitor channel's measurement stream, the programmable
// qualification settings and the resulting health status/alarms.
//   master : drives measurement + configuration, observes status/alarms
//   slave  : the health FSM (consumes measurement, produces status/alarms)
// Signals
//   rate, rate_valid, locked       measurement stream from the monitor
//   rate_min, rate_max             inclusive good window
//   n_bad, n_good                  debounce thresholds (0 behaves as 1)
//   alarm_clear                    clears alarm_sticky and bad_events
//   status, alarm, alarm_sticky,
//   bad_events, stale              health outputs
// ---------------------------------------------------------------------------
interface clk_health_fsm_if #(
  parameter int RATE_W = 24,
  parameter int CNT_W  = 4
);
  logic [RATE_W-1:0] rate;
  logic              rate_valid;
  logic              locked;
  logic [RATE_W-1:0] rate_min;
  logic [RATE_W-1:0] rate_max;
  logic [CNT_W-1:0]  n_bad;
  logic [CNT_W-1:0]  n_good;
  logic              alarm_clear;
  logic [2:0]        status;
  logic              alarm;
  logic              alarm_sticky;
  logic [15:0]       bad_events;
  logic              stale;

  modport master (
    output rate, rate_valid, locked, rate_min, rate_max, n_bad, n_good, alarm_clear,
    input  status, alarm, alarm_sticky, bad_events, stale
  );

  modport slave (
    input  rate, rate_valid, locked, rate_min, rate_max, n_bad, n_good, alarm_clear,
    output status, alarm, alarm_sticky, bad_events, stale
  );
endinterface

// File: rtl/clk_health_fsm.sv
// ---------------------------------------------------------------------------
// clk_health_fsm
// Qualifies each rate measurement of one monitored clock against a window,
// debounces good/bad verdicts, detects a stale measurement stream and
// produces live and sticky alarms. Everything runs in the clk_ref domain.
// Ports
//   clk_ref : reference clock
//   reset   : asynchronous, active-high reset
//   mon     : clk_health_fsm_if.slave (measurement/config in, status out)
// Status encoding: 0 INIT, 1 OK, 2 SUSPECT, 3 FAIL, 4 RECOVER
// ---------------------------------------------------------------------------
module clk_health_fsm #(
  parameter int RATE_W      = 24,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 150000000,
  parameter int TO_W        = 28
) (
  input  logic             clk_ref,
  input  logic             reset,
  clk_health_fsm_if.slave  mon
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OK      = 3'd1,
    ST_SUSPECT = 3'd2,
    ST_FAIL    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  // A programmed threshold of zero behaves like one.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] n);
    if (n == CNT_ZERO) begin
      at_least_one = CNT_ONE;
    end else begin
      at_least_one = n;
    end
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               alarm_q, alarm_d;
  logic               sticky_q, sticky_d;
  logic [15:0]        bad_q, bad_d;
  logic               stale_q, stale_d;

  logic               sample_good_s;
  logic               sample_bad_s;
  logic               timeout_hit_s;
  logic [CNT_W-1:0]   nb_s, ng_s;
  logic [CNT_W:0]     cnt_inc_s;
  logic               reach_nb_s, reach_ng_s;

  assign sample_good_s = mon.locked && (mon.rate >= mon.rate_min) && (mon.rate <= mon.rate_max);
  assign sample_bad_s  = mon.rate_valid && !sample_good_s;
  // Fires only on the cycle the counter reaches the limit, i.e. once per gap.
  assign timeout_hit_s = !mon.rate_valid && (to_q == TO_LAST);
  assign nb_s          = at_least_one(mon.n_bad);
  assign ng_s          = at_least_one(mon.n_good);
  assign cnt_inc_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // ">=" so a threshold lowered below the running count trips on the next sample.
  assign reach_nb_s    = cnt_inc_s >= {1'b0, nb_s};
  assign reach_ng_s    = cnt_inc_s >= {1'b0, ng_s};

  // State and debounce counter registers.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: lock loss and timeout override the sample-driven table.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mon.locked || timeout_hit_s) begin
      state_d = ST_FAIL;
      cnt_d   = CNT_ZERO;
    end else if (mon.rate_valid) begin
      case (state_q)
        ST_INIT, ST_OK: begin
          if (sample_good_s) begin
            state_d = ST_OK;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = (nb_s == CNT_ONE) ? ST_FAIL : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (sample_good_s) begin
            state_d = ST_OK;
            cnt_d   = CNT_ZERO;
          end else if (reach_nb_s) begin
            state_d = ST_FAIL;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_SUSPECT;
            cnt_d   = cnt_inc_s[CNT_W-1:0];
          end
        end
        ST_FAIL: begin
          if (!sample_good_s) begin
            state_d = ST_FAIL;
            cnt_d   = CNT_ZERO;
          end else if (ng_s == CNT_ONE) begin
            state_d = ST_OK;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RECOVER;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RECOVER: begin
          if (!sample_good_s) begin
            state_d = ST_FAIL;
            cnt_d   = CNT_ZERO;
          end else if (reach_ng_s) begin
            state_d = ST_OK;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RECOVER;
            cnt_d   = cnt_inc_s[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Output next-values: timeout counter, stale flag, alarms, bad-sample count.
  always_comb begin
    to_d     = to_q;
    stale_d  = stale_q;
    alarm_d  = (state_d == ST_FAIL);
    sticky_d = sticky_q;
    bad_d    = bad_q;

    if (mon.rate_valid) begin
      to_d    = {TO_W{1'b0}};
      stale_d = 1'b0;
    end else if (to_q != TO_LIMIT) begin
      to_d    = to_q + TO_ONE;
      stale_d = timeout_hit_s ? 1'b1 : stale_q;
    end else begin
      to_d    = to_q;
      stale_d = stale_q;
    end

    // Set wins over clear so a FAIL entry is never lost.
    if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
      sticky_d = 1'b1;
    end else if (mon.alarm_clear) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    if (mon.alarm_clear) begin
      bad_d = sample_bad_s ? 16'd1 : 16'd0;
    end else if (sample_bad_s && (bad_q != 16'hFFFF)) begin
      bad_d = bad_q + 16'd1;
    end else begin
      bad_d = bad_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      to_q     <= {TO_W{1'b0}};
      stale_q  <= 1'b0;
      alarm_q  <= 1'b0;
      sticky_q <= 1'b0;
      bad_q    <= 16'd0;
    end else begin
      to_q     <= to_d;
      stale_q  <= stale_d;
      alarm_q  <= alarm_d;
      sticky_q <= sticky_d;
      bad_q    <= bad_d;
    end
  end

  assign mon.status       = state_q;
  assign mon.alarm        = alarm_q;
  assign mon.alarm_sticky = sticky_q;
  assign mon.bad_events   = bad_q;
  assign mon.stale        = stale_q;

endmodule

// File: tb/tb_clk_health_fsm.sv
// ---------------------------------------------------------------------------
// tb_clk_health_fsm
// Table-driven bench for clk_health_fsm with a small shortened timeout.
// Each record holds one cycle of inputs and the outputs expected after the
// following clk_ref edge; expected records go through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_clk_health_fsm;

  localparam int RATE_W = 24;
  localparam int CNT_W  = 4;
  localparam int TO_CYC = 1000;

  localparam int G  = 100000;
  localparam int B  = 50000;
  localparam int LO = 99000;
  localparam int HI = 101000;

  typedef struct {
    logic [RATE_W-1:0] rate;
    logic              valid;
    logic              locked;
    logic [RATE_W-1:0] rmin;
    logic [RATE_W-1:0] rmax;
    logic [CNT_W-1:0]  nb;
    logic [CNT_W-1:0]  ng;
    logic              clr;
    logic [2:0]        st;
    logic              alarm;
    logic              sticky;
    logic [15:0]       be;
    logic              stale;
  } vec_t;

  logic clk_ref;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];
  vec_t exp_q[$];

  clk_health_fsm_if #(.RATE_W(RATE_W), .CNT_W(CNT_W)) mon ();

  clk_health_fsm #(
    .RATE_W(RATE_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TO_CYC), .TO_W(28)
  ) dut (
    .clk_ref (clk_ref),
    .reset   (reset),
    .mon     (mon.slave)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  function automatic vec_t mk(input int rate, input int valid, input int locked,
                              input int rmin, input int rmax, input int nb, input int ng,
                              input int clr, input int st, input int alarm,
                              input int sticky, input int be, input int stale);
    vec_t v;
    v.rate = RATE_W'(rate); v.valid = 1'(valid); v.locked = 1'(locked);
    v.rmin = RATE_W'(rmin); v.rmax = RATE_W'(rmax);
    v.nb = CNT_W'(nb); v.ng = CNT_W'(ng); v.clr = 1'(clr);
    v.st = 3'(st); v.alarm = 1'(alarm); v.sticky = 1'(sticky);
    v.be = 16'(be); v.stale = 1'(stale);
    return v;
  endfunction

  task automatic check(input vec_t e, input string tag);
    n_tests++;
    if (mon.status !== e.st || mon.alarm !== e.alarm || mon.alarm_sticky !== e.sticky ||
        mon.bad_events !== e.be || mon.stale !== e.stale) begin
      n_fail++;
      $display("FAIL %s: got st=%0d alarm=%0b sticky=%0b be=%0d stale=%0b, want st=%0d alarm=%0b sticky=%0b be=%0d stale=%0b",
               tag, mon.status, mon.alarm, mon.alarm_sticky, mon.bad_events, mon.stale,
               e.st, e.alarm, e.sticky, e.be, e.stale);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk_ref);
    mon.rate = v.rate; mon.rate_valid = v.valid; mon.locked = v.locked;
    mon.rate_min = v.rmin; mon.rate_max = v.rmax;
    mon.n_bad = v.nb; mon.n_good = v.ng; mon.alarm_clear = v.clr;
    exp_q.push_back(v);
    @(posedge clk_ref);
    #1;
    e = exp_q.pop_front();
    check(e, tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    mon.rate = RATE_W'(G); mon.rate_valid = 1'b0; mon.locked = 1'b1;
    mon.rate_min = RATE_W'(LO); mon.rate_max = RATE_W'(HI);
    mon.n_bad = 4'd3; mon.n_good = 4'd2; mon.alarm_clear = 1'b0;

    // rate  vld lck min max nb ng clr | st alm stk be stale
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 1, 0, 0, 0, 0)); // INIT good -> OK
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 2, 0, 0, 1, 0)); // bad 1
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 2, 0, 0, 2, 0)); // bad 2
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 3, 1, 1, 3, 0)); // bad 3 -> FAIL
    tbl.push_back(mk(G,    0, 1, LO, HI, 3, 2, 0, 3, 1, 1, 3, 0)); // idle holds
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 4, 0, 1, 3, 0)); // -> RECOVER
    tbl.push_back(mk(HI,   1, 1, LO, HI, 3, 2, 0, 1, 0, 1, 3, 0)); // max inclusive -> OK
    tbl.push_back(mk(G,    0, 1, LO, HI, 3, 2, 1, 1, 0, 0, 0, 0)); // alarm_clear
    tbl.push_back(mk(G,    0, 0, LO, HI, 3, 2, 0, 3, 1, 1, 0, 0)); // lock loss, no strobe
    tbl.push_back(mk(LO,   1, 1, LO, HI, 3, 2, 0, 4, 0, 1, 0, 0)); // min inclusive
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 1, 0, 1, 0, 0)); // -> OK
    tbl.push_back(mk(98999,1, 1, LO, HI, 0, 2, 1, 3, 1, 1, 1, 0)); // nb=0, clr on entry + bad
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 1, 0, 1, 0, 1, 1, 0)); // ng=1 FAIL -> OK
    tbl.push_back(mk(G,    1, 1, HI, LO, 3, 2, 0, 2, 0, 1, 2, 0)); // min>max -> bad
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 1, 0, 1, 2, 0)); // SUSPECT good -> OK
    tbl.push_back(mk(G,    1, 0, LO, HI, 3, 2, 0, 3, 1, 1, 3, 0)); // unlocked strobe
    tbl.push_back(mk(G,    0, 1, LO, HI, 3, 2, 1, 3, 1, 0, 0, 0)); // clear keeps FAIL
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 4, 0, 0, 0, 0)); // -> RECOVER
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 3, 1, 1, 1, 0)); // RECOVER bad -> FAIL
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 4, 0, 1, 1, 0));
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 2, 0, 1, 2, 0)); // cnt=1
    tbl.push_back(mk(B,    1, 1, LO, HI, 3, 2, 0, 2, 0, 1, 3, 0)); // cnt=2
    tbl.push_back(mk(G,    0, 1, LO, HI, 2, 2, 0, 2, 0, 1, 3, 0)); // nb lowered, no sample
    tbl.push_back(mk(B,    1, 1, LO, HI, 2, 2, 0, 3, 1, 1, 4, 0)); // next sample decides
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 4, 0, 1, 4, 0));
    tbl.push_back(mk(G,    1, 1, LO, HI, 3, 2, 0, 1, 0, 1, 4, 0));

    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    reset = 1'b0;
    #1;
    check(mk(G, 0, 1, LO, HI, 3, 2, 0, 0, 0, 0, 0, 0), "reset");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Strobe gap: stale and forced FAIL exactly on the TO_CYC-th idle cycle.
    for (int k = 1; k <= TO_CYC; k++) begin
      if (k == TO_CYC) begin
        step(mk(G, 0, 1, LO, HI, 3, 2, 0, 3, 1, 1, 4, 1), "timeout_fire");
      end else begin
        step(mk(G, 0, 1, LO, HI, 3, 2, 0, 1, 0, 1, 4, 0), $sformatf("gap%0d", k));
      end
    end
    step(mk(G, 0, 1, LO, HI, 3, 2, 0, 3, 1, 1, 4, 1), "stale_hold");
    step(mk(G, 0, 1, LO, HI, 3, 2, 1, 3, 1, 0, 0, 1), "stale_clr");
    step(mk(G, 0, 1, LO, HI, 3, 2, 0, 3, 1, 0, 0, 1), "stale_hold2");
    step(mk(G, 1, 1, LO, HI, 3, 2, 0, 4, 0, 0, 0, 0), "stale_good");
    step(mk(101001, 1, 1, LO, HI, 3, 2, 0, 3, 1, 1, 1, 0), "above_max");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
